// File: rtl/video_pkg.sv
// Shared video-path types and defaults for the raster sources and the pixel pipeline.
package video_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef logic [11:0] rgb444_t;
  typedef logic [3:0]  grey_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } src_state_t;

  // $clog2 that never returns 0, so degenerate sizes still give a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_stream_source_if.sv
// RAM read port plus the valid-strobe pixel stream of a raster source.
interface frame_stream_source_if
  import video_pkg::*;
#(
  parameter int ADDR_W = 19
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  rgb444_t           mem_rdata;
  rgb444_t           pixel_out;
  logic              out_ready;
  logic              sof;
  logic              eol;

  modport master (
    output mem_addr, mem_rd_en, pixel_out, out_ready, sof, eol,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, pixel_out, out_ready, sof, eol,
    output mem_rdata
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y walker with a linear address kept in step by increment only.
module raster_counter
  import video_pkg::*;
#(
  parameter int W  = IMG_W_DEF,
  parameter int H  = IMG_H_DEF,
  parameter int XW = clog2_min1(W),
  parameter int YW = clog2_min1(H),
  parameter int AW = clog2_min1(W * H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr,
  output logic          last_x,
  output logic          last_y
);

  assign last_x = (x == XW'(W - 1));
  assign last_y = (y == YW'(H - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
      // Wrap at the frame end so the address never leaves the image.
      addr <= (last_x && last_y) ? '0 : addr + AW'(1);
    end
  end

endmodule

// File: rtl/frame_stream_source.sv
// Streams a stored RGB444 frame from synchronous RAM as a raster-order valid-strobe pixel stream.
//
// state  | meaning
// IDLE   | waiting for start
// ACTIVE | one RAM read per cycle along the current line
// GAP    | H_GAP idle cycles between lines
// DONE   | frame bookkeeping; in continuous mode it also reads pixel (0,0) of the next frame
module frame_stream_source
  import video_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int H_GAP      = 0,
  parameter int CONTINUOUS = 0,
  parameter int ADDR_W     = clog2_min1(IMG_W * IMG_H)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [15:0] frame_cnt,
  frame_stream_source_if.master bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACTIVE = ACTIVE;
  localparam logic [1:0] ST_GAP    = GAP;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam int XW = clog2_min1(IMG_W);
  localparam int YW = clog2_min1(IMG_H);
  localparam int GW = clog2_min1(H_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'((H_GAP > 0) ? H_GAP - 1 : 0);

  logic [1:0]        state, state_nx, step_nx;
  logic              reading, clear;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              last_x, last_y;
  logic [GW-1:0]     gap_cnt;
  rgb444_t           pix_hold;

  raster_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .XW (XW),
    .YW (YW),
    .AW (ADDR_W)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (reading),
    .x       (x),
    .y       (y),
    .addr    (addr),
    .last_x  (last_x),
    .last_y  (last_y)
  );

  // Back-to-back continuous frames: DONE issues the first read of the next frame.
  assign reading = (state == ST_ACTIVE) || ((CONTINUOUS != 0) && (state == ST_DONE));
  assign clear   = (state == ST_IDLE) && start;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    if (last_x && last_y)           step_nx = ST_DONE;
    else if (last_x && (H_GAP > 0)) step_nx = ST_GAP;
    else                            step_nx = ST_ACTIVE;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_ACTIVE;
      ST_ACTIVE: state_nx = step_nx;
      ST_GAP:    if (gap_cnt == '0) state_nx = ST_ACTIVE;
      ST_DONE:   state_nx = (CONTINUOUS != 0) ? step_nx : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (reading && (step_nx == ST_GAP)) gap_cnt <= GAP_LOAD;
      else if ((state == ST_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GW'(1);
      if (state == ST_DONE) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign bus.mem_rd_en = reading;
  assign bus.mem_addr  = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_ready <= 1'b0;
      bus.sof       <= 1'b0;
      bus.eol       <= 1'b0;
      pix_hold      <= '0;
    end else begin
      bus.out_ready <= reading;
      bus.sof       <= reading && (x == '0) && (y == '0);
      bus.eol       <= reading && last_x;
      if (bus.out_ready) pix_hold <= bus.mem_rdata;
    end
  end

  // RAM data lands in the strobe cycle; hold it afterwards so idle cycles show the last pixel.
  assign bus.pixel_out = bus.out_ready ? bus.mem_rdata : pix_hold;

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source: four configurations fed by RAM models, checked against a raster-timing model.
module tb_frame_stream_source;
  import video_pkg::*;

  typedef struct {
    int cyc;
    int pix;
    bit sof;
    bit eol;
    int fcnt;
  } strobe_t;

  int geo_w [4] = '{8, 8, 8, 1};
  int geo_h [4] = '{4, 4, 4, 4};
  int geo_g [4] = '{0, 3, 0, 2};

  logic        clk = 1'b0;
  logic        rst   [4];
  logic        start [4];
  logic        busy  [4];
  logic [15:0] frame_cnt [4];
  int          cyc = 0;
  rgb444_t     ram [4][32];

  strobe_t q0[$], q1[$], q2[$], q3[$];
  int      addr_bad [4] = '{0, 0, 0, 0};
  int      hold_bad [4] = '{0, 0, 0, 0};
  rgb444_t last_pix [4] = '{12'h0, 12'h0, 12'h0, 12'h0};

  int n_pass = 0, n_total = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_stream_source_if #(.ADDR_W(5)) bus0 ();
  frame_stream_source_if #(.ADDR_W(5)) bus1 ();
  frame_stream_source_if #(.ADDR_W(5)) bus2 ();
  frame_stream_source_if #(.ADDR_W(2)) bus3 ();

  frame_stream_source #(.IMG_W(8), .IMG_H(4), .H_GAP(0), .CONTINUOUS(0)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .frame_cnt(frame_cnt[0]), .bus(bus0));
  frame_stream_source #(.IMG_W(8), .IMG_H(4), .H_GAP(3), .CONTINUOUS(0)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .frame_cnt(frame_cnt[1]), .bus(bus1));
  frame_stream_source #(.IMG_W(8), .IMG_H(4), .H_GAP(0), .CONTINUOUS(1)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy[2]), .frame_cnt(frame_cnt[2]), .bus(bus2));
  frame_stream_source #(.IMG_W(1), .IMG_H(4), .H_GAP(2), .CONTINUOUS(0)) u3 (
    .clk(clk), .rst(rst[3]), .start(start[3]), .busy(busy[3]), .frame_cnt(frame_cnt[3]), .bus(bus3));

  // Synchronous RAMs: data one cycle after the read enable.
  always @(posedge clk) begin
    if (bus0.mem_rd_en) bus0.mem_rdata <= ram[0][bus0.mem_addr];
    if (bus1.mem_rd_en) bus1.mem_rdata <= ram[1][bus1.mem_addr];
    if (bus2.mem_rd_en) bus2.mem_rdata <= ram[2][bus2.mem_addr];
    if (bus3.mem_rd_en) bus3.mem_rdata <= ram[3][bus3.mem_addr];
  end

  task automatic sample(input int d, input logic ordy, input rgb444_t pix,
                        input logic s, input logic e, input int addr);
    strobe_t r;
    r = '{cyc, int'(pix), s, e, int'(frame_cnt[d])};
    if (ordy === 1'b1) begin
      case (d)
        0:       q0.push_back(r);
        1:       q1.push_back(r);
        2:       q2.push_back(r);
        default: q3.push_back(r);
      endcase
      last_pix[d] = pix;
    end else if (rst[d] === 1'b0 && pix !== last_pix[d]) begin
      hold_bad[d]++;
    end
    if (rst[d] === 1'b0 && addr >= geo_w[d] * geo_h[d]) addr_bad[d]++;
    if (rst[d] === 1'b1) last_pix[d] = '0;
  endtask

  always @(negedge clk) begin
    sample(0, bus0.out_ready, bus0.pixel_out, bus0.sof, bus0.eol, int'(bus0.mem_addr));
    sample(1, bus1.out_ready, bus1.pixel_out, bus1.sof, bus1.eol, int'(bus1.mem_addr));
    sample(2, bus2.out_ready, bus2.pixel_out, bus2.sof, bus2.eol, int'(bus2.mem_addr));
    sample(3, bus3.out_ready, bus3.pixel_out, bus3.sof, bus3.eol, int'(bus3.mem_addr));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, input string tag, output int low_cyc);
    int k = 0;
    while (busy[d] !== 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_timeout"}, busy[d] === 1'b0, 1);
    low_cyc = cyc;
  endtask

  // Model: strobe i of a frame started in cycle c0 lies in cycle c0+2+i plus H_GAP per completed line.
  task automatic check_frame(input int d, input int nframes, input int c0, input string tag, input bit exact);
    strobe_t cur[$];
    int n, total, period, k, f, w, g;
    w = geo_w[d];
    g = geo_g[d];
    n = w * geo_h[d];
    total = n * nframes;
    period = n + (geo_h[d] - 1) * g;
    case (d)
      0:       cur = q0;
      1:       cur = q1;
      2:       cur = q2;
      default: cur = q3;
    endcase
    if (exact) chk({tag, "_count"}, cur.size(), total);
    else       chk({tag, "_count"}, cur.size() >= total, 1);
    if (cur.size() >= total) begin
      for (int i = 0; i < total; i++) begin
        k = i % n;
        f = i / n;
        chk($sformatf("%s_pix%0d", tag, i), cur[i].pix, ram[d][k]);
        chk($sformatf("%s_sof%0d", tag, i), cur[i].sof, k == 0);
        chk($sformatf("%s_eol%0d", tag, i), cur[i].eol, (k % w) == w - 1);
        chk($sformatf("%s_cyc%0d", tag, i), cur[i].cyc, c0 + 2 + f * period + k + (k / w) * g);
      end
    end
  endtask

  initial begin
    int c0, c2, lc;
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1;
      start[d] = 1'b0;
      for (int a = 0; a < 32; a++) ram[d][a] = (d == 0) ? rgb444_t'(a) : rgb444_t'($urandom);
    end

    // start held together with rst must be lost
    start[0] = 1'b1;
    tick(3);
    chk("rst_out_ready", bus0.out_ready, 0);
    chk("rst_mem_rd_en", bus0.mem_rd_en, 0);
    chk("rst_mem_addr",  bus0.mem_addr, 0);
    chk("rst_pixel_out", bus0.pixel_out, 0);
    chk("rst_sof",       bus0.sof, 0);
    chk("rst_eol",       bus0.eol, 0);
    chk("rst_busy",      busy[0], 0);
    chk("rst_frame_cnt", frame_cnt[0], 0);
    chk("rst_busy3",     busy[3], 0);
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;
    start[0] = 1'b0;
    tick(1);
    chk("rst_wins_start", busy[0], 0);

    // single frames: ramp, gapped lines, one-pixel lines; u0 gets a second start on strobe 10
    tick($urandom_range(1, 4));
    c0 = cyc;
    start[0] = 1'b1;
    start[1] = 1'b1;
    start[3] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    start[1] = 1'b0;
    start[3] = 1'b0;
    tick(11);
    pulse_start(0);
    wait_idle(0, 100, "a0", lc);
    chk("a0_busy_fall", lc, c0 + 2 + 31 + 1);
    wait_idle(1, 100, "a1", lc);
    chk("a1_busy_fall", lc, c0 + 2 + 32 + 3 * 3);
    check_frame(0, 1, c0, "a0", 1'b1);
    check_frame(1, 1, c0, "a1", 1'b1);
    check_frame(3, 1, c0, "a3", 1'b1);
    chk("a0_frame_cnt", frame_cnt[0], 1);
    chk("a1_frame_cnt", frame_cnt[1], 1);
    chk("a3_frame_cnt", frame_cnt[3], 1);
    chk("a3_busy",      busy[3], 0);
    chk("a0_addr_wrap", bus0.mem_addr, 0);
    chk("a1_addr_wrap", bus1.mem_addr, 0);
    chk("a3_addr_wrap", bus3.mem_addr, 0);

    // continuous mode: three full frames plus the sof of the fourth
    tick($urandom_range(1, 4));
    c2 = cyc;
    pulse_start(2);
    tick(3 * 32 + 8);
    check_frame(2, 3, c2, "c2", 1'b0);
    chk("c2_len", q2.size() > 96, 1);
    if (q2.size() > 96) begin
      for (int f = 0; f <= 3; f++) begin
        chk($sformatf("c2_fcnt%0d", f), q2[32 * f].fcnt, f);
        chk($sformatf("c2_sof%0d", f),  q2[32 * f].sof, 1);
        chk($sformatf("c2_cyc%0d", f),  q2[32 * f].cyc, c2 + 2 + 32 * f);
      end
    end
    chk("c2_busy", busy[2], 1);
    rst[2] = 1'b1;
    tick(1);
    rst[2] = 1'b0;
    chk("c2_rst_busy", busy[2], 0);
    chk("c2_rst_frame_cnt", frame_cnt[2], 0);

    // abort mid-frame on strobe 13, then replay with fresh random contents
    for (int a = 0; a < 32; a++) ram[0][a] = rgb444_t'($urandom);
    q0.delete();
    c0 = cyc;
    pulse_start(0);
    tick(14);
    rst[0] = 1'b1;
    tick(1);
    chk("r_out_ready", bus0.out_ready, 0);
    chk("r_pixel_out", bus0.pixel_out, 0);
    chk("r_sof",       bus0.sof, 0);
    chk("r_eol",       bus0.eol, 0);
    chk("r_mem_rd_en", bus0.mem_rd_en, 0);
    chk("r_mem_addr",  bus0.mem_addr, 0);
    chk("r_busy",      busy[0], 0);
    chk("r_frame_cnt", frame_cnt[0], 0);
    chk("r_strobes",   q0.size(), 14);
    rst[0] = 1'b0;
    tick($urandom_range(1, 3));
    q0.delete();
    c0 = cyc;
    pulse_start(0);
    wait_idle(0, 100, "r2", lc);
    check_frame(0, 1, c0, "r2", 1'b1);
    chk("r2_frame_cnt", frame_cnt[0], 1);

    for (int d = 0; d < 4; d++) begin
      chk($sformatf("addr_range%0d", d), addr_bad[d], 0);
      chk($sformatf("pixel_hold%0d", d), hold_bad[d], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
